// File: rtl/bt_telemetry_server.sv
// bt_telemetry_server: UART request/response server for telemetry reads and config writes
module bt_telemetry_server #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16,
  parameter int NUM_CFG = 4,
  parameter logic [NUM_CFG*8-1:0] CFG_INIT = '0,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_byte,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CFG*8-1:0]     cfg,
  output logic                     cfg_wr,
  output logic [6:0]               cfg_wr_idx,
  output logic [7:0]               drop_cnt,
  output logic                     busy
);
  localparam int NB = (DATA_W + 7) / 8;
  localparam int SW = NB * 8;
  localparam int RW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] ACK = SW'(8'h01) << (SW - 8);
  typedef enum logic [1:0] {IDLE, WAIT_VAL, SEND, HOLD} state_t;
  state_t state;
  logic [SW-1:0] snap, reply;
  logic [RW-1:0] rem, reply_n;
  logic [TW-1:0] tmo;
  logic [6:0] idx;
  logic [DATA_W-1:0] ch_sel;
  logic rd_ok, wr_ok, accept;
  // Decode the byte that either starts a read or completes a write into a reply image
  always_comb begin
    ch_sel = DATA_W'(ch_data >> (DATA_W * int'(rx_byte[6:0])));
    rd_ok = int'(rx_byte[6:0]) < NUM_CH;
    wr_ok = int'(idx) < NUM_CFG;
    accept = rx_valid && ((state == IDLE && !rx_byte[7]) || state == WAIT_VAL);
    reply = state == IDLE ? (rd_ok ? SW'(ch_sel) : '0) : (wr_ok ? ACK : '0);
    reply_n = (state == IDLE && rd_ok) ? RW'(NB) : RW'(1);
  end
  // Request FSM; the first reply byte goes out on the accepting edge when the UART is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      snap <= '0;
      rem <= '0;
      tmo <= '0;
      idx <= '0;
      tx_start <= 1'b0;
      tx_byte <= 8'h00;
      cfg <= CFG_INIT;
      cfg_wr <= 1'b0;
      cfg_wr_idx <= '0;
      drop_cnt <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      cfg_wr <= 1'b0;
      if (rx_valid && (state == SEND || state == HOLD) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (accept) begin
        if (state == WAIT_VAL && wr_ok) begin
          cfg[8*idx +: 8] <= rx_byte;
          cfg_wr <= 1'b1;
          cfg_wr_idx <= idx;
        end
        if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_byte <= reply[SW-1 -: 8];
          snap <= reply << 8;
          rem <= reply_n - RW'(1);
          state <= HOLD;
        end else begin
          snap <= reply;
          rem <= reply_n;
          state <= SEND;
        end
      end else begin
        case (state)
          IDLE: if (rx_valid) begin
            idx <= rx_byte[6:0];
            tmo <= '0;
            state <= WAIT_VAL;
          end
          WAIT_VAL: if (tmo == TW'(TIMEOUT - 1)) state <= IDLE; else tmo <= tmo + TW'(1);
          SEND: if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte <= snap[SW-1 -: 8];
            snap <= snap << 8;
            rem <= rem - RW'(1);
            state <= HOLD;
          end
          HOLD: state <= rem != '0 ? SEND : IDLE;
        endcase
      end
    end
  end
  assign busy = state != IDLE;
endmodule
